// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: MEM-stage access to word-aligned data memory bus
// Handles byte enables, lane replication, load extension, misalign and memory time-out.
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_wr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            misalign,
  output logic            bus_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      wait_cnt_q;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic            dmem_req_q, dmem_we_q;
  logic [XLEN-1:0] dmem_addr_q, dmem_wdata_q, rdata_q;
  logic [3:0]      dmem_be_q;
  logic            rdata_valid_q, misalign_q, bus_err_q;

  logic            legal;
  logic            last_wait;
  logic [3:0]      be_st;
  logic [XLEN-1:0] wd_st;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'd0:       legal = 1'b1;
      3'd1:       legal = ~addr[0];
      3'd2:       legal = (addr[1:0] == 2'b00);
      3'd4:       legal = ~req_wr;
      3'd5:       legal = ~req_wr & ~addr[0];
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    be_st = 4'b1111;
    wd_st = wdata;
    case (funct3[1:0])
      2'd0: begin
        be_st = 4'b0001 << addr[1:0];
        wd_st = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_st = addr[1] ? 4'b1100 : 4'b0011;
        wd_st = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the offset and funct3 latched at accept time, not the live inputs.
  always_comb begin
    ld_byte = dmem_rdata[8*off_q +: 8];
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  assign last_wait = (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = legal ? S_WAIT : S_RESP;
      S_WAIT:  if (dmem_ack || last_wait) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = ~rst & (((state_q == S_IDLE) & req_valid) | (state_q == S_WAIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      off_q         <= '0;
      f3_q          <= '0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_be_q     <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && legal) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= req_wr;
            dmem_addr_q  <= {addr[XLEN-1:2], 2'b00};
            dmem_be_q    <= req_wr ? be_st : 4'b1111;
            dmem_wdata_q <= req_wr ? wd_st : '0;
            off_q        <= addr[1:0];
            f3_q         <= funct3;
            wait_cnt_q   <= '0;
          end else if (req_valid) begin
            misalign_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          // An ack in the final allowed cycle takes priority over the time-out.
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (!dmem_we_q) begin
              rdata_q       <= ld_ext;
              rdata_valid_q <= 1'b1;
            end
          end else if (last_wait) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign dmem_be     = dmem_be_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign misalign    = misalign_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed bench for lsu with a cycle-by-cycle memory responder
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_wr, dmem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, dmem_rdata;
  logic        stall, rdata_valid, misalign, bus_err, dmem_req, dmem_we;
  logic [31:0] rdata, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;

  int n_cmp = 0;
  int n_mis = 0;

  int          r_stalls, r_val, r_mis, r_berr, r_req, r_unstable;
  logic        r_req0, we_cap;
  logic [31:0] r_rdata, a_cap, wd_cap;
  logic [3:0]  be_cap;

  lsu #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misalign(misalign), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ack_at: WAIT cycle (1-based) in which memory acks; 0 = never.
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] mem, input int ack_at,
                        input bit keep);
    int wc = 0;
    int cyc = 0;
    bit done = 0;
    r_stalls = 0; r_val = 0; r_mis = 0; r_berr = 0; r_unstable = 0; r_rdata = '0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; funct3 = f3; addr = a; wdata = wd; dmem_rdata = mem;
    r_req0 = dmem_req;
    while (!done && cyc < 400) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (dmem_req) begin
        wc++;
        if (wc == 1) begin
          we_cap = dmem_we; be_cap = dmem_be; a_cap = dmem_addr; wd_cap = dmem_wdata;
        end else if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {we_cap, be_cap, a_cap, wd_cap}) begin
          r_unstable++;
        end
        dmem_ack = (wc == ack_at);
      end else begin
        dmem_ack = 1'b0;
      end
      #1;
      if (rdata_valid) begin r_val++; r_rdata = rdata; end
      if (misalign) r_mis++;
      if (bus_err) begin r_berr++; r_rdata = rdata; end
      if (stall) r_stalls++;
      else done = 1;
    end
    r_req = wc;
    check("resp_reached", 32'(done), 1);
    dmem_ack = 1'b0;
    if (!keep) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("quiet_after", {27'd0, dmem_req, stall, rdata_valid, misalign, bus_err}, 0);
    end
  endtask

  task automatic expect_res(input string n, input int stalls, input int val, input int mis,
                            input int berr, input int nreq);
    check({n, "_stall"}, r_stalls, stalls);
    check({n, "_pulses"}, {r_val[7:0], r_mis[7:0], r_berr[7:0]}, {val[7:0], mis[7:0], berr[7:0]});
    check({n, "_reqcyc"}, r_req, nreq);
    check({n, "_req0"}, 32'(r_req0), 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_wr = 1'b0; funct3 = 3'd2; addr = '0; wdata = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl", {24'd0, dmem_req, dmem_we, rdata_valid, misalign, bus_err, stall, 2'd0}, 0);
    check("reset_be", {28'd0, dmem_be}, 0);
    check("reset_rdata", rdata, 0);
    check("reset_addr", dmem_addr, 0);
    check("reset_wdata", dmem_wdata, 0);
    req_valid = 1'b0;
    rst = 1'b0;

    access(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 1, 0);
    expect_res("sb", 2, 0, 0, 0, 1);
    check("sb_addr", a_cap, 32'h100);
    check("sb_be", {28'd0, be_cap}, 32'h8);
    check("sb_wdata", wd_cap, 32'hA5A5_A5A5);
    check("sb_we", 32'(we_cap), 1);

    access(1'b1, 3'd1, 32'h102, 32'h1234_BEEF, 32'h0, 1, 0);
    expect_res("sh", 2, 0, 0, 0, 1);
    check("sh_be", {28'd0, be_cap}, 32'hC);
    check("sh_wdata", wd_cap, 32'hBEEF_BEEF);

    access(1'b0, 3'd0, 32'h202, 32'h0, 32'h80F1_7E01, 1, 0);
    expect_res("lb", 2, 1, 0, 0, 1);
    check("lb_rdata", r_rdata, 32'hFFFF_FFF1);
    check("lb_addr", a_cap, 32'h200);
    check("lb_be_we", {27'd0, we_cap, be_cap}, 32'hF);
    access(1'b0, 3'd4, 32'h202, 32'h0, 32'h80F1_7E01, 1, 0);
    check("lbu_rdata", r_rdata, 32'h0000_00F1);
    access(1'b0, 3'd1, 32'h202, 32'h0, 32'h80F1_7E01, 1, 0);
    check("lh_rdata", r_rdata, 32'hFFFF_80F1);
    access(1'b0, 3'd5, 32'h202, 32'h0, 32'h80F1_7E01, 1, 0);
    check("lhu_rdata", r_rdata, 32'h0000_80F1);
    access(1'b0, 3'd2, 32'h200, 32'h0, 32'h80F1_7E01, 1, 0);
    expect_res("lw", 2, 1, 0, 0, 1);
    check("lw_rdata", r_rdata, 32'h80F1_7E01);

    access(1'b0, 3'd2, 32'h204, 32'h0, 32'h0BAD_F00D, 5, 0);
    expect_res("lw_wait5", 6, 1, 0, 0, 5);
    check("lw_wait5_stable", r_unstable, 0);
    check("lw_wait5_rdata", r_rdata, 32'h0BAD_F00D);

    access(1'b0, 3'd2, 32'h200, 32'h0, 32'h5555_5555, 0, 0);
    expect_res("timeout", 17, 0, 0, 1, 16);
    check("timeout_rdata", r_rdata, 0);
    check("timeout_stable", r_unstable, 0);

    access(1'b0, 3'd2, 32'h208, 32'h0, 32'h1357_9BDF, 16, 0);
    expect_res("ack16", 17, 1, 0, 0, 16);
    check("ack16_rdata", r_rdata, 32'h1357_9BDF);

    access(1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 1, 0);
    expect_res("lh_mis", 1, 0, 1, 0, 0);
    access(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1, 0);
    expect_res("f3_3", 1, 0, 1, 0, 0);
    access(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 1, 0);
    expect_res("store_f3_4", 1, 0, 1, 0, 0);
    access(1'b1, 3'd2, 32'h102, 32'h0, 32'h0, 1, 0);
    expect_res("sw_mis", 1, 0, 1, 0, 0);

    access(1'b1, 3'd2, 32'h300, 32'hDEAD_BEEF, 32'h0, 1, 1);
    expect_res("b2b_sw", 2, 0, 0, 0, 1);
    check("b2b_sw_wdata", wd_cap, 32'hDEAD_BEEF);
    access(1'b0, 3'd2, 32'h304, 32'h0, 32'hCAFE_F00D, 1, 0);
    expect_res("b2b_lw", 2, 1, 0, 0, 1);
    check("b2b_lw_we_addr", {we_cap, a_cap[30:0]}, 32'h304);
    check("b2b_lw_rdata", r_rdata, 32'hCAFE_F00D);

    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; funct3 = 3'd2; addr = 32'h400; wdata = 32'h1234_5678;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midwait_req", {31'd0, dmem_req}, 1);
    rst = 1'b1;
    #1;
    check("midwait_rst_stall", {31'd0, stall}, 0);
    @(negedge clk);
    #1;
    check("midwait_rst_ctl", {26'd0, dmem_req, dmem_we, rdata_valid, misalign, bus_err, stall}, 0);
    check("midwait_rst_data", dmem_addr | dmem_wdata | rdata | {28'd0, dmem_be}, 0);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midwait_after", {27'd0, dmem_req, stall, rdata_valid, misalign, bus_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
